// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param
//   Pipeline hazard controller placed between ID decode and the PC/IF/ID
//   stages. Detects load-use, jump, jr-dependency and branch-mispredict
//   hazards. It drives the PC write enable, the IF/ID write and flush, the
//   ID/EX bubble and the next-PC select.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to add saturating
//   stall/flush performance counters.
//
// Handshake: this block has no valid/ready interfaces. Every input is a
//   level sampled each cycle. Responses are combinational in the same cycle,
//   and state changes take effect on the next rising edge of Clk.
//
// Ports
//   Clk, Rst            clock; synchronous active-high reset
//   Jump, Jr, Branch    control-flow class of the ID instruction
//   taken               branch predicted taken
//   needFlush           branch resolved mispredicted (only looked at in BR0)
//   memReadEX           EX instruction is a load
//   UseShamt, UseImmed  ID instruction does not read rt
//   currRs, currRt      ID source registers
//   prevRt              EX load destination
//   rwRegW              per downstream stage {rw, regW}; stage 0 is nearest
//   PC_Write, IF_Write, IF_Flush, bubble, addrSel   pipeline control
//   dbg_state, dbg_ld_cnt                           FSM observation
//   stall_cycles, flush_events                      (HAZARD_PERF_CNT_EN only)
module hazard_ctrl_param #(
    parameter int RA_W      = 5,
    parameter int JR_STAGES = 2,
    parameter int LD_STALL  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Jump,
    input  logic                          Jr,
    input  logic                          Branch,
    input  logic                          taken,
    input  logic                          needFlush,
    input  logic                          memReadEX,
    input  logic                          UseShamt,
    input  logic                          UseImmed,
    input  logic [RA_W-1:0]               currRs,
    input  logic [RA_W-1:0]               currRt,
    input  logic [RA_W-1:0]               prevRt,
    input  logic [JR_STAGES*(RA_W+1)-1:0] rwRegW,
    output logic                          PC_Write,
    output logic                          IF_Write,
    output logic                          IF_Flush,
    output logic                          bubble,
    output logic [1:0]                    addrSel,
    output logic [2:0]                    dbg_state,
    output logic [2:0]                    dbg_ld_cnt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_events
`endif
);

    typedef enum logic [2:0] {
        NOHZ = 3'd0,
        LDST = 3'd1,
        JMP  = 3'd2,
        JRW  = 3'd3,
        BR0  = 3'd4,
        BR1  = 3'd5
    } state_t;

    // Tuple layout: {PC_Write, IF_Write, IF_Flush, bubble, addrSel}
    localparam logic [5:0] T_IDLE  = 6'b110000;
    localparam logic [5:0] T_JUMP  = 6'b100001;
    localparam logic [5:0] T_JRW   = 6'b000101;
    localparam logic [5:0] T_JRGO  = 6'b100101;
    localparam logic [5:0] T_LDST  = 6'b000100;
    localparam logic [5:0] T_BRTK  = 6'b100010;
    localparam logic [5:0] T_BRNT  = 6'b110000;
    localparam logic [5:0] T_FLUSH = 6'b101111;
    localparam logic [5:0] T_RST   = 6'b001100;

    // The first stall cycle is spent in NOHZ, so LDST waits LD_STALL-1 more.
    localparam logic [2:0] LD_INIT = 3'(LD_STALL - 1);

    state_t     state_q, state_d;
    logic [2:0] ld_cnt_q, ld_cnt_d;
    logic [5:0] tuple;

    logic ld_haz;
    logic jr_dep;

    always_comb begin
        ld_haz = memReadEX && (prevRt != '0) &&
                 ((currRs == prevRt) ||
                  ((currRt == prevRt) && !UseImmed && !UseShamt));
    end

    // A write to $zero never creates a real dependency.
    always_comb begin
        jr_dep = 1'b0;
        for (int i = 0; i < JR_STAGES; i++) begin
            if (rwRegW[i*(RA_W+1)] &&
                (rwRegW[i*(RA_W+1)+1 +: RA_W] == currRs) &&
                (currRs != '0)) begin
                jr_dep = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        tuple    = T_IDLE;
        case (state_q)
            NOHZ: begin
                if (Jump) begin
                    state_d = JMP;
                    tuple   = T_JUMP;
                end else if (Jr && jr_dep) begin
                    state_d = JRW;
                    tuple   = T_JRW;
                end else if (Jr) begin
                    state_d = JMP;
                    tuple   = T_JRGO;
                end else if (ld_haz) begin
                    state_d  = LDST;
                    ld_cnt_d = LD_INIT;
                    tuple    = T_LDST;
                end else if (Branch && taken) begin
                    state_d = BR0;
                    tuple   = T_BRTK;
                end else if (Branch) begin
                    state_d = BR0;
                    tuple   = T_BRNT;
                end
            end
            LDST: begin
                if (ld_cnt_q != 3'd0) begin
                    ld_cnt_d = ld_cnt_q - 3'd1;
                    tuple    = T_LDST;
                end else begin
                    state_d = NOHZ;
                end
            end
            JMP: begin
                state_d = NOHZ;
            end
            JRW: begin
                if (jr_dep) begin
                    tuple = T_JRW;
                end else begin
                    state_d = JMP;
                    tuple   = T_JRGO;
                end
            end
            BR0: begin
                if (needFlush) begin
                    state_d = BR1;
                    tuple   = T_FLUSH;
                end else begin
                    state_d = NOHZ;
                end
            end
            BR1: begin
                state_d = NOHZ;
            end
            default: begin
                state_d = NOHZ;
            end
        endcase
        // Reset overrides both the outputs and the next state.
        if (Rst) begin
            state_d  = NOHZ;
            ld_cnt_d = 3'd0;
            tuple    = T_RST;
        end
    end

    always_ff @(posedge Clk) begin
        state_q  <= state_d;
        ld_cnt_q <= ld_cnt_d;
    end

    always_comb begin
        {PC_Write, IF_Write, IF_Flush, bubble, addrSel} = tuple;
        dbg_state  = state_q;
        dbg_ld_cnt = ld_cnt_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (Rst) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (!PC_Write && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + 1'b1;
            end
            if ((state_q == BR0) && needFlush && (flush_events_q != '1)) begin
                flush_events_d = flush_events_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        stall_cycles_q <= stall_cycles_d;
        flush_events_q <= flush_events_d;
    end

    always_comb begin
        stall_cycles = stall_cycles_q;
        flush_events = flush_events_q;
    end
`endif

endmodule
